// File: rtl/lieat_vreg_pkg.sv
// Shared types and helpers for the parametrised vector register file:
// LMUL encodings, write-sequencer state, group sizing and membership.
package lieat_vreg_pkg;

   localparam logic [1:0] LMUL1 = 2'd0;
   localparam logic [1:0] LMUL2 = 2'd1;
   localparam logic [1:0] LMUL4 = 2'd2;
   localparam logic [1:0] LMUL8 = 2'd3;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } wseq_state_e;

   function automatic int unsigned reg_idx_w(input int unsigned nreg);
      return (nreg > 1) ? $clog2(nreg) : 1;
   endfunction

   // Registers in a group, with the encoded LMUL clipped to lmul_max.
   function automatic int unsigned group_size(input logic [1:0] lmul,
                                              input int unsigned lmul_max);
      int unsigned sz;
      sz = 32'd1 << lmul;
      return (sz > lmul_max) ? lmul_max : sz;
   endfunction

   // True when idx lies in [base, base+size) modulo nreg.
   function automatic logic in_group(input int unsigned idx,
                                     input int unsigned base,
                                     input int unsigned size,
                                     input int unsigned nreg);
      return ((idx + nreg - base) % nreg) < size;
   endfunction

endpackage

// File: rtl/lieat_vreg_wseq.sv
// Writeback sequencer: valid/ready capture into a staging buffer, then
// commits WPC registers of the staged group per cycle.
module lieat_vreg_wseq
   import lieat_vreg_pkg::*;
#(
   parameter  int unsigned XLEN     = 32,
   parameter  int unsigned NREG     = 32,
   parameter  int unsigned LMUL_MAX = 8,
   parameter  int unsigned WPC      = 2,
   localparam int unsigned RW       = reg_idx_w(NREG),
   localparam int unsigned NB       = XLEN / 8,
   localparam int unsigned BW       = $clog2(LMUL_MAX) + 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [RW-1:0]                 wr_rd,
   input  logic [1:0]                    wr_lmul,
   input  logic [LMUL_MAX*NB-1:0]        wr_bmask,
   input  logic [LMUL_MAX*XLEN-1:0]      wr_data,
   output logic                          wr_done,
   output logic [NREG-1:0]               commit_en,
   output logic [NREG-1:0][NB-1:0]       commit_bmask,
   output logic [NREG-1:0][XLEN-1:0]     commit_data
);

   wseq_state_e                state, state_nxt;
   logic [BW-1:0]              beat, beat_nxt;
   logic [RW-1:0]              stg_rd;
   logic [1:0]                 stg_lmul;
   logic [LMUL_MAX*NB-1:0]     stg_bmask;
   logic [LMUL_MAX*XLEN-1:0]   stg_data;
   int unsigned                stg_size;
   int unsigned                n_beats;
   int unsigned                k;
   logic [RW-1:0]              idx;
   logic                       last_beat;

   always_comb begin
      stg_size  = group_size(stg_lmul, LMUL_MAX);
      n_beats   = (stg_size > WPC) ? stg_size / WPC : 1;
      last_beat = (32'(beat) == n_beats - 1);
   end

   always_comb begin
      state_nxt = state;
      beat_nxt  = beat;
      wr_ready  = (state == IDLE);
      wr_done   = 1'b0;
      unique case (state)
         IDLE: begin
            if (wr_valid) begin
               state_nxt = WRITE;
               beat_nxt  = '0;
            end
         end
         WRITE: begin
            beat_nxt = beat + 1'b1;
            if (last_beat) begin
               wr_done   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         beat      <= '0;
         stg_rd    <= '0;
         stg_lmul  <= '0;
         stg_bmask <= '0;
         stg_data  <= '0;
      end else begin
         state <= state_nxt;
         beat  <= beat_nxt;
         if (wr_valid && wr_ready) begin
            stg_rd    <= wr_rd;
            stg_lmul  <= wr_lmul;
            stg_bmask <= wr_bmask;
            stg_data  <= wr_data;
         end
      end
   end

   // Slot j of this beat maps staged slice k onto register (rd + k) mod NREG.
   always_comb begin
      commit_en    = '0;
      commit_bmask = '0;
      commit_data  = '0;
      k            = 0;
      idx          = '0;
      if (state == WRITE) begin
         for (int unsigned j = 0; j < WPC; j++) begin
            k = 32'(beat) * WPC + j;
            if (k < stg_size) begin
               idx               = RW'(32'(stg_rd) + k);
               commit_en[idx]    = 1'b1;
               commit_bmask[idx] = stg_bmask[k*NB +: NB];
               commit_data[idx]  = stg_data[k*XLEN +: XLEN];
            end
         end
      end
   end

endmodule

// File: rtl/lieat_vregfile_seq.sv
// Parametrised vector register file with write sequencer and busy scoreboard.
// Define VREG_BYPASS_EN to forward same-cycle commits to the read ports.
module lieat_vregfile_seq
   import lieat_vreg_pkg::*;
#(
   parameter  int unsigned XLEN     = 32,
   parameter  int unsigned NREG     = 32,
   parameter  int unsigned LMUL_MAX = 8,
   parameter  int unsigned WPC      = 2,
   localparam int unsigned RW       = reg_idx_w(NREG),
   localparam int unsigned NB       = XLEN / 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [RW-1:0]            rd_vs1,
   input  logic [RW-1:0]            rd_vs2,
   input  logic [1:0]               rd_lmul,
   output logic [LMUL_MAX*XLEN-1:0] rd_vsrc1,
   output logic [LMUL_MAX*XLEN-1:0] rd_vsrc2,
   output logic                     rd_busy,
   output logic [XLEN-1:0]          vreg_mask,
   input  logic                     alloc_valid,
   input  logic [RW-1:0]            alloc_rd,
   input  logic [1:0]               alloc_lmul,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [RW-1:0]            wr_rd,
   input  logic [1:0]               wr_lmul,
   input  logic [LMUL_MAX*NB-1:0]   wr_bmask,
   input  logic [LMUL_MAX*XLEN-1:0] wr_data,
   output logic                     wr_done
);

   logic [NREG-1:0][XLEN-1:0] vregs, merged, rd_view;
   logic [NREG-1:0]           busy, busy_nxt, busy_view;
   logic [NREG-1:0]           commit_en;
   logic [NREG-1:0][NB-1:0]   commit_bmask;
   logic [NREG-1:0][XLEN-1:0] commit_data;
   int unsigned               alloc_size;
   int unsigned               rd_size;

   lieat_vreg_wseq #(
      .XLEN     (XLEN),
      .NREG     (NREG),
      .LMUL_MAX (LMUL_MAX),
      .WPC      (WPC)
   ) u_wseq (
      .clock        (clock),
      .reset        (reset),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_rd        (wr_rd),
      .wr_lmul      (wr_lmul),
      .wr_bmask     (wr_bmask),
      .wr_data      (wr_data),
      .wr_done      (wr_done),
      .commit_en    (commit_en),
      .commit_bmask (commit_bmask),
      .commit_data  (commit_data)
   );

   // Byte-enables are zero for non-committing registers, so merged == vregs there.
   always_comb begin
      merged = vregs;
      for (int unsigned i = 0; i < NREG; i++)
         for (int unsigned b = 0; b < NB; b++)
            if (commit_bmask[i][b])
               merged[i][b*8 +: 8] = commit_data[i][b*8 +: 8];
   end

   // Commit clears first, alloc sets after, so a same-edge alloc wins.
   always_comb begin
      alloc_size = group_size(alloc_lmul, LMUL_MAX);
      busy_nxt   = busy & ~commit_en;
      for (int unsigned i = 0; i < NREG; i++)
         if (alloc_valid && in_group(i, 32'(alloc_rd), alloc_size, NREG))
            busy_nxt[i] = 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vregs <= '0;
         busy  <= '0;
      end else begin
         vregs <= merged;
         busy  <= busy_nxt;
      end
   end

   always_comb begin
`ifdef VREG_BYPASS_EN
      rd_view   = merged;
      busy_view = busy & ~commit_en;
`else
      rd_view   = vregs;
      busy_view = busy;
`endif
   end

   always_comb begin
      rd_size  = group_size(rd_lmul, LMUL_MAX);
      rd_vsrc1 = '0;
      rd_vsrc2 = '0;
      rd_busy  = 1'b0;
      for (int unsigned k = 0; k < LMUL_MAX; k++) begin
         if (k < rd_size) begin
            rd_vsrc1[k*XLEN +: XLEN] = rd_view[RW'(32'(rd_vs1) + k)];
            rd_vsrc2[k*XLEN +: XLEN] = rd_view[RW'(32'(rd_vs2) + k)];
         end
      end
      for (int unsigned i = 0; i < NREG; i++)
         if (busy_view[i] && (in_group(i, 32'(rd_vs1), rd_size, NREG) ||
                              in_group(i, 32'(rd_vs2), rd_size, NREG)))
            rd_busy = 1'b1;
   end

   assign vreg_mask = vregs[0];

endmodule
